// File: rtl/memory_bus_controller.sv
// Core-side load/store router: splits traffic between a synchronous word RAM and a handshaked peripheral port.
// Optional peripheral timeout is enabled with `define BUS_TIMEOUT_EN.
module memory_bus_controller #(
  parameter logic [31:0] PERIPH_BASE    = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [2:0]  core_option,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  output logic [31:0] core_read_data,
  output logic        core_response,
  output logic        ram_enable,
  output logic [3:0]  ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        periph_read,
  output logic        periph_write,
  output logic [31:0] periph_address,
  output logic [2:0]  periph_option,
  output logic [31:0] periph_wdata,
  input  logic [31:0] periph_rdata,
  input  logic        periph_ack,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, RAM_READ, PERIPH_WAIT, RESPOND} state_t;

  state_t      state, state_next;
  logic [31:0] lat_addr;
  logic [2:0]  lat_opt;
  logic [31:0] lat_data;
  logic        lat_write;
  logic        req;
  logic        is_periph;
  logic        timeout;

  assign req       = core_read | core_write;
  assign is_periph = (core_address >= PERIPH_BASE);

  assign periph_address = lat_addr;
  assign periph_option  = lat_opt;
  assign periph_wdata   = lat_data;

  function automatic logic [3:0] store_lanes(input logic [1:0] opt, input logic [1:0] a);
    case (opt)
      2'd0:    return 4'b0001 << a;
      2'd1:    return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] opt, input logic [31:0] d);
    case (opt)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] opt, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {a, 3'b000};
    b       = shifted[7:0];
    h       = a[1] ? w[31:16] : w[15:0];
    case (opt)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

`ifdef BUS_TIMEOUT_EN
  logic [31:0] wait_count;
  logic        err_flag;

  assign timeout   = (state == PERIPH_WAIT) && !periph_ack && (wait_count == TIMEOUT_CYCLES - 32'd1);
  assign bus_error = (state == RESPOND) && err_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_count <= '0;
      err_flag   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        wait_count <= '0;
        err_flag   <= 1'b0;
      end else if (state == PERIPH_WAIT) begin
        wait_count <= wait_count + 32'd1;
        if (timeout) err_flag <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign bus_error          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (is_periph)       state_next = PERIPH_WAIT;
          else if (core_write) state_next = RESPOND;
          else                 state_next = RAM_READ;
        end
      end
      RAM_READ:    state_next = RESPOND;
      PERIPH_WAIT: if (periph_ack || timeout) state_next = RESPOND;
      RESPOND:     state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // RAM is addressed straight from the core inputs in the accept cycle so its 1-cycle latency overlaps the FSM step.
  always_comb begin
    ram_enable    = 1'b0;
    ram_we        = '0;
    ram_addr      = '0;
    ram_wdata     = '0;
    periph_read   = 1'b0;
    periph_write  = 1'b0;
    core_response = 1'b0;
    case (state)
      IDLE: begin
        if (req && !is_periph) begin
          ram_enable = 1'b1;
          ram_addr   = core_address[31:2];
          if (core_write) begin
            ram_we    = store_lanes(core_option[1:0], core_address[1:0]);
            ram_wdata = store_data(core_option[1:0], core_write_data);
          end
        end
      end
      PERIPH_WAIT: begin
        periph_read  = !lat_write;
        periph_write = lat_write;
      end
      RESPOND: core_response = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr       <= '0;
      lat_opt        <= '0;
      lat_data       <= '0;
      lat_write      <= 1'b0;
      core_read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= core_address;
            lat_opt   <= core_option;
            lat_data  <= core_write_data;
            lat_write <= core_write;
          end
        end
        RAM_READ: core_read_data <= load_align(lat_opt, lat_addr[1:0], ram_rdata);
        PERIPH_WAIT: begin
          if (periph_ack) begin
            if (!lat_write) core_read_data <= periph_rdata;
          end else if (timeout) begin
            core_read_data <= '1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_controller.sv
// Directed bench for memory_bus_controller: RAM stores/loads, peripheral handshake, reset abort, timeout (BUS_TIMEOUT_EN).
module tb_memory_bus_controller;

`ifdef BUS_TIMEOUT_EN
  localparam int ACK_WAIT = 3;
`else
  localparam int ACK_WAIT = 5;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        core_read, core_write;
  logic [2:0]  core_option;
  logic [31:0] core_address, core_write_data, core_read_data;
  logic        core_response;
  logic        ram_enable;
  logic [3:0]  ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        periph_read, periph_write;
  logic [31:0] periph_address, periph_wdata, periph_rdata;
  logic [2:0]  periph_option;
  logic        periph_ack;
  logic        bus_error;

  logic [31:0] ram_word;
  int checks = 0;
  int errors = 0;

  memory_bus_controller #(.PERIPH_BASE(32'h8000_0000), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .core_read(core_read), .core_write(core_write), .core_option(core_option),
    .core_address(core_address), .core_write_data(core_write_data),
    .core_read_data(core_read_data), .core_response(core_response),
    .ram_enable(ram_enable), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .periph_read(periph_read), .periph_write(periph_write),
    .periph_address(periph_address), .periph_option(periph_option),
    .periph_wdata(periph_wdata), .periph_rdata(periph_rdata),
    .periph_ack(periph_ack), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_enable) ram_rdata <= ram_word;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (core_response !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", core_response); end
    checks++; if (core_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", core_read_data); end
    checks++; if ({periph_read, periph_write, ram_enable, ram_we, bus_error} !== 8'h00) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000000", {periph_read, periph_write, ram_enable, ram_we, bus_error}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ram_store();
    logic [2:0]  opt   [3] = '{3'd0, 3'd1, 3'd2};
    logic [31:0] addr  [3] = '{32'h0000_0003, 32'h0000_0003, 32'h0000_0105};
    logic [31:0] data  [3] = '{32'h0000_00A5, 32'h1234_BEEF, 32'hCAFE_F00D};
    logic [3:0]  we    [3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] wdata [3] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'hCAFE_F00D};
    logic [29:0] waddr [3] = '{30'h0, 30'h0, 30'h41};
    for (int i = 0; i < 3; i++) begin
      core_write = 1'b1; core_option = opt[i]; core_address = addr[i]; core_write_data = data[i];
      #1;
      checks++; if ({ram_enable, ram_we} !== {1'b1, we[i]}) begin errors++; $display("FAIL store%0d_we: got %b want %b", i, {ram_enable, ram_we}, {1'b1, we[i]}); end
      checks++; if (ram_wdata !== wdata[i]) begin errors++; $display("FAIL store%0d_wdata: got %h want %h", i, ram_wdata, wdata[i]); end
      checks++; if (ram_addr !== waddr[i]) begin errors++; $display("FAIL store%0d_addr: got %h want %h", i, ram_addr, waddr[i]); end
      @(negedge clk);
      core_write = 1'b0;
      checks++; if (core_response !== 1'b1) begin errors++; $display("FAIL store%0d_resp: got %b want 1", i, core_response); end
      @(negedge clk);
      checks++; if (core_response !== 1'b0) begin errors++; $display("FAIL store%0d_resp_end: got %b want 0", i, core_response); end
    end
  endtask

  task automatic test_write_priority();
    core_read = 1'b1; core_write = 1'b1; core_option = 3'd2; core_address = 32'h20; core_write_data = 32'h5555_AAAA;
    #1;
    checks++; if (ram_we !== 4'b1111) begin errors++; $display("FAIL prio_we: got %b want 1111", ram_we); end
    @(negedge clk);
    core_read = 1'b0; core_write = 1'b0;
    checks++; if (core_response !== 1'b1) begin errors++; $display("FAIL prio_resp: got %b want 1", core_response); end
    @(negedge clk);
  endtask

  task automatic test_ram_load();
    logic [2:0]  opt  [6] = '{3'd1, 3'd5, 3'd0, 3'd4, 3'd0, 3'd2};
    logic [31:0] addr [6] = '{32'h2, 32'h2, 32'h1, 32'h3, 32'h3, 32'h0};
    logic [31:0] exp  [6] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_007F,
                              32'h0000_0080, 32'hFFFF_FF80, 32'h8001_7FFF};
    ram_word = 32'h8001_7FFF;
    for (int i = 0; i < 6; i++) begin
      core_read = 1'b1; core_option = opt[i]; core_address = addr[i];
      #1;
      checks++; if ({ram_enable, ram_we} !== 5'b10000) begin errors++; $display("FAIL load%0d_en: got %b want 10000", i, {ram_enable, ram_we}); end
      @(negedge clk);
      checks++; if ({core_response, ram_enable} !== 2'b00) begin errors++; $display("FAIL load%0d_busy: got %b want 00", i, {core_response, ram_enable}); end
      @(negedge clk);
      core_read = 1'b0;
      checks++; if (core_response !== 1'b1) begin errors++; $display("FAIL load%0d_resp: got %b want 1", i, core_response); end
      checks++; if (core_read_data !== exp[i]) begin errors++; $display("FAIL load%0d_data: got %h want %h", i, core_read_data, exp[i]); end
      @(negedge clk);
      checks++; if (core_response !== 1'b0 || core_read_data !== exp[i]) begin
        errors++; $display("FAIL load%0d_hold: got %b/%h want 0/%h", i, core_response, core_read_data, exp[i]); end
    end
  endtask

  task automatic test_stray_ack();
    periph_ack = 1'b1; periph_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    periph_ack = 1'b0;
    checks++; if (core_response !== 1'b0 || core_read_data !== 32'h8001_7FFF) begin
      errors++; $display("FAIL stray_ack: got %b/%h want 0/80017fff", core_response, core_read_data); end
    @(negedge clk);
  endtask

  task automatic test_periph_read();
    core_read = 1'b1; core_option = 3'd2; core_address = 32'h8000_0010;
    #1;
    checks++; if (ram_enable !== 1'b0) begin errors++; $display("FAIL pr_ram_en: got %b want 0", ram_enable); end
    for (int i = 1; i <= ACK_WAIT; i++) begin
      @(negedge clk);
      core_read = 1'b0;
      checks++; if ({periph_read, periph_write, core_response} !== 3'b100) begin
        errors++; $display("FAIL pr_wait%0d: got %b want 100", i, {periph_read, periph_write, core_response}); end
      if (i == ACK_WAIT) begin periph_ack = 1'b1; periph_rdata = 32'h1234_5678; end
    end
    checks++; if (periph_address !== 32'h8000_0010 || periph_option !== 3'd2) begin
      errors++; $display("FAIL pr_addr: got %h/%0d want 80000010/2", periph_address, periph_option); end
    @(negedge clk);
    periph_ack = 1'b0;
    checks++; if (core_response !== 1'b1 || periph_read !== 1'b0) begin errors++; $display("FAIL pr_resp: got %b/%b want 1/0", core_response, periph_read); end
    checks++; if (core_read_data !== 32'h1234_5678) begin errors++; $display("FAIL pr_data: got %h want 12345678", core_read_data); end
    @(negedge clk);
    checks++; if (core_response !== 1'b0) begin errors++; $display("FAIL pr_resp_end: got %b want 0", core_response); end
  endtask

  task automatic test_periph_write();
    core_write = 1'b1; core_option = 3'd0; core_address = 32'hFFFF_FFFC; core_write_data = 32'h0000_00C3;
    @(negedge clk);
    core_write = 1'b0;
    checks++; if ({periph_write, periph_read} !== 2'b10 || periph_wdata !== 32'h0000_00C3 || periph_option !== 3'd0) begin
      errors++; $display("FAIL pw_strobe: got %b/%h/%0d want 10/000000c3/0", {periph_write, periph_read}, periph_wdata, periph_option); end
    periph_ack = 1'b1; periph_rdata = 32'h7777_7777;
    @(negedge clk);
    periph_ack = 1'b0;
    checks++; if (core_response !== 1'b1 || periph_write !== 1'b0) begin errors++; $display("FAIL pw_resp: got %b/%b want 1/0", core_response, periph_write); end
    checks++; if (core_read_data !== 32'h1234_5678) begin errors++; $display("FAIL pw_rdata_hold: got %h want 12345678", core_read_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    core_read = 1'b1; core_option = 3'd2; core_address = 32'h8000_0040;
    @(negedge clk);
    core_read = 1'b0;
    @(negedge clk);
    checks++; if (periph_read !== 1'b1) begin errors++; $display("FAIL rm_wait: got %b want 1", periph_read); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({periph_read, core_response, bus_error} !== 3'b000 || core_read_data !== 32'h0) begin
      errors++; $display("FAIL rm_abort: got %b/%h want 000/00000000", {periph_read, core_response, bus_error}, core_read_data); end
    begin
      int seen = 0;
      repeat (3) begin @(negedge clk); if (core_response) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL rm_no_resp: got %0d responses want 0", seen); end
    end
    ram_word = 32'hDEAD_BEEF;
    core_read = 1'b1; core_option = 3'd2; core_address = 32'h100;
    @(negedge clk);
    core_read = 1'b0;
    @(negedge clk);
    checks++; if (core_response !== 1'b1 || core_read_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rm_followup: got %b/%h want 1/deadbeef", core_response, core_read_data); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    core_read = 1'b1; core_option = 3'd2; core_address = 32'h9000_0000;
`ifdef BUS_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      core_read = 1'b0;
      checks++; if ({core_response, bus_error, periph_read} !== 3'b001) begin
        errors++; $display("FAIL to_wait%0d: got %b want 001", i, {core_response, bus_error, periph_read}); end
    end
    @(negedge clk);
    checks++; if ({core_response, bus_error, periph_read} !== 3'b110) begin
      errors++; $display("FAIL to_resp: got %b want 110", {core_response, bus_error, periph_read}); end
    checks++; if (core_read_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_data: got %h want ffffffff", core_read_data); end
    @(negedge clk);
    checks++; if ({core_response, bus_error} !== 2'b00) begin errors++; $display("FAIL to_end: got %b want 00", {core_response, bus_error}); end
`else
    begin
      int seen = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        core_read = 1'b0;
        if (core_response || bus_error) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL to_no_resp: got %0d responses want 0", seen); end
      checks++; if (periph_read !== 1'b1) begin errors++; $display("FAIL to_still_wait: got %b want 1", periph_read); end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b1; core_read = 1'b0; core_write = 1'b0; core_option = '0;
    core_address = '0; core_write_data = '0; periph_rdata = '0; periph_ack = 1'b0;
    ram_word = '0;
    @(negedge clk);
    test_reset();
    test_ram_store();
    test_write_priority();
    test_ram_load();
    test_stray_ack();
    test_periph_read();
    test_periph_write();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_bus_controller.md
MEMORY_BUS_CONTROLLER -- requirements
Module: memory_bus_controller

Interface
REQ-001 Parameter PERIPH_BASE, default 32'h8000_0000: addresses >= PERIPH_BASE route to the peripheral port; all others route to RAM.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: peripheral wait limit; used only when BUS_TIMEOUT_EN is defined.
REQ-003 Signal clk, input, 1 bit: clock; all logic is on its rising edge.
REQ-004 Signal reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Signals core_read / core_write, input, 1 bit each: core transfer requests.
REQ-006 Signal core_option, input, 3 bits: RISC-V funct3 access size (0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores use 0 SB, 1 SH, 2 SW).
REQ-007 Signals core_address / core_write_data, input, 32 bits each: byte address and store data (store data is LSB-justified).
REQ-008 Signal core_read_data, output, 32 bits: aligned and extended load result.
REQ-009 Signal core_response, output, 1 bit: one-cycle pulse marking transfer completion.
REQ-010 Signals ram_enable, output, 1 bit; ram_we, output, 4 bits; ram_addr, output, 30 bits; ram_wdata, output, 32 bits; ram_rdata, input, 32 bits: synchronous word RAM port with 1-cycle read latency.
REQ-011 Signals periph_read / periph_write, output, 1 bit each; periph_address, output, 32 bits; periph_option, output, 3 bits; periph_wdata, output, 32 bits; periph_rdata, input, 32 bits; periph_ack, input, 1 bit: peripheral port.
REQ-012 Signal bus_error, output, 1 bit: pulses together with core_response on a timed-out transfer.

Function
REQ-013 The FSM SHALL have four states: IDLE, RAM_READ, PERIPH_WAIT and RESPOND.
REQ-014 In IDLE, core_read or core_write SHALL latch address, option and data; a write SHALL take priority if both are asserted.
REQ-015 RAM write: in the accept cycle, drive ram_enable=1, ram_addr=address[31:2], ram_we per REQ-017, then go to RESPOND; core_response asserts 1 cycle after accept.
REQ-016 RAM read: in the accept cycle, drive ram_enable=1 and ram_we=0, then go to RAM_READ; in RAM_READ, align ram_rdata into core_read_data and go to RESPOND; core_response asserts 2 cycles after accept.
REQ-017 Store lanes: SB gives ram_we=4'b0001<<a[1:0] with the byte replicated x4; SH gives ram_we=4'b0011<<{a[1],1'b0} with the half replicated x2; SW gives 4'b1111; address bits below the access size are ignored.
REQ-018 Load extraction: LB/LBU select byte a[1:0] with sign/zero extension; LH/LHU select half a[1] with sign/zero extension; LW and options 3, 6, 7 return the whole word.
REQ-019 Peripheral access: hold periph_read or periph_write plus address, option and raw data from the cycle after accept until periph_ack; on ack, capture periph_rdata unmodified, drop the strobes on the same edge, and go to RESPOND.
REQ-020 RESPOND SHALL pulse core_response for exactly 1 cycle, then return to IDLE; the core deasserts its request in the cycle after core_response.
REQ-021 Requests arriving outside IDLE SHALL be ignored; core_read_data SHALL hold its value until the next load completes.
REQ-022 A periph_ack outside PERIPH_WAIT SHALL be ignored.

Reset
REQ-023 Reset, including mid-transaction, SHALL force IDLE at the next edge, with core_read_data=0, core_response=0, bus_error=0, all strobes and ram_we at 0, and no response issued for an aborted transfer.

Configuration
REQ-024 With BUS_TIMEOUT_EN defined, a counter SHALL run in PERIPH_WAIT; if no ack arrives within TIMEOUT_CYCLES cycles, drop the strobes, set core_read_data=32'hFFFF_FFFF, and go to RESPOND with bus_error=1.
REQ-025 Without BUS_TIMEOUT_EN, PERIPH_WAIT SHALL wait indefinitely and bus_error SHALL be tied to 0.

Verification
REQ-026 SB addr 0x0000_0003, data 0x0000_00A5 -> ram_we=4'b1000, ram_wdata=0xA5A5A5A5, response 1 cycle later.
REQ-027 RAM word 0x8001_7FFF, LH at addr 2 -> 0xFFFF8001; LHU at addr 2 -> 0x0000_8001; LB at addr 1 -> 0x0000_007F; each response 2 cycles after accept.
REQ-028 LW at 0x8000_0010, ack after 5 cycles with rdata 0x1234_5678 -> core_read_data=0x12345678, one response pulse, strobes low after ack.
REQ-029 Reset asserted while in PERIPH_WAIT -> IDLE, strobes low, no core_response, and a following RAM LW completes normally.
REQ-030 With BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no ack -> response and bus_error pulse together, core_read_data=0xFFFFFFFF; without the macro, no response ever.
